// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, stallable memory read port, QDEPTH-entry queue, decode redirect/halt.
// Accepted words are visible at out_* the cycle after accept; requests stop when the queue is full, and pending requests are held until accepted.
module fetch_unit #(
  parameter int unsigned ADDR_W       = 32,
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h0,
  parameter int unsigned QDEPTH       = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] instr_address,
  output logic              instr_read,
  input  logic              instr_waitrequest,
  input  logic [31:0]       instr_readdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halt
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [ADDR_W-1:0] RV   = ADDR_W'(RESET_VECTOR);
  localparam logic [ADDR_W-1:0] HA   = ADDR_W'(HALT_ADDR) & ~ADDR_W'(3);
  localparam logic [CW-1:0]     FULL = CW'(QDEPTH);

  typedef enum logic [1:0] {S_FETCH, S_DISCARD, S_HALTED} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              halt_q, halt_d;

  logic [ADDR_W-1:0] q_pc    [QDEPTH];
  logic [31:0]       q_instr [QDEPTH];
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]     count_q;

  logic              accept, pending, pop, push, redir, redir_halt;
  logic [ADDR_W-1:0] redir_addr;
  logic [ADDR_W-1:0] disc_tgt;
  logic              disc_halt;

  // pc_q is the address of the in-flight request; it must not move until accept.
  assign instr_address = pc_q;
  assign instr_read    = ~reset & (((state_q == S_FETCH) && (count_q != FULL)) ||
                                   (state_q == S_DISCARD));
  assign accept        = instr_read & ~instr_waitrequest;
  assign pending       = instr_read & instr_waitrequest;
  assign out_valid     = (count_q != '0);
  assign out_pc        = q_pc[rd_ptr_q];
  assign out_instr     = q_instr[rd_ptr_q];
  assign halt          = halt_q;
  assign pop           = out_valid & out_ready;

  assign redir_addr = redirect_target & ~ADDR_W'(3);
  assign redir      = redirect_valid & ~halt_q & (state_q != S_HALTED);
  assign redir_halt = redir & (redir_addr == HA);
  assign push       = accept & (state_q == S_FETCH) & ~redir;
  assign disc_tgt   = redir ? redir_addr : tgt_q;
  assign disc_halt  = halt_q | redir_halt;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    halt_d  = halt_q;
    case (state_q)
      S_FETCH: begin
        if (redir) begin
          halt_d = redir_halt;
          if (pending) begin
            state_d = S_DISCARD;
            tgt_d   = redir_addr;
          end else begin
            pc_d    = redir_addr;
            state_d = redir_halt ? S_HALTED : S_FETCH;
          end
        end else if (accept) begin
          pc_d = pc_q + ADDR_W'(4);
        end
      end
      S_DISCARD: begin
        tgt_d  = disc_tgt;
        halt_d = disc_halt;
        if (accept) begin
          pc_d    = disc_tgt;
          state_d = disc_halt ? S_HALTED : S_FETCH;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RV;
      tgt_q   <= RV;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      halt_q  <= halt_d;
    end
  end

  // A pop in the redirect cycle is simply lost with the flush, which is what decode expects.
  always_ff @(posedge clk) begin
    if (reset || redir) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr_q]    <= pc_q;
      q_instr[wr_ptr_q] <= instr_readdata;
    end
  end

endmodule
